sap_datapath: RTL and testbench

Register-transfer datapath that executes the 15-bit control word produced by the instruction controller. Holds the PC, MAR, 16×8 RAM, IR, A/B registers, adder/subtractor, output register and halt latch, all on one shared 8-bit bus. Returns the opcode (`IR[7:4]`) and the run enable to the controller, closing the fetch/execute loop.

---
 rtl/sap_pkg.sv | 58 +++++
 rtl/sap_ram16x8.sv | 32 +++
 rtl/sap_datapath.sv | 117 +++++++++++
 tb/tb_sap_datapath.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared constants for the SAP datapath -- control-word bit
// positions, opcodes and the bus-source priority decode.
package sap_pkg;

    localparam int CTRL_W = 15;

    // Control-word bit positions, {HLT ... J} from bit 14 down to bit 0
    localparam int HLT_B = 14;
    localparam int MI_B  = 13;
    localparam int RI_B  = 12;
    localparam int RO_B  = 11;
    localparam int IO_B  = 10;
    localparam int II_B  = 9;
    localparam int AI_B  = 8;
    localparam int AO_B  = 7;
    localparam int SO_B  = 6;
    localparam int SU_B  = 5;
    localparam int BI_B  = 4;
    localparam int OI_B  = 3;
    localparam int CE_B  = 2;
    localparam int CO_B  = 1;
    localparam int J_B   = 0;

    // Opcodes decoded by the controller from IR[7:4]
    localparam logic [3:0] OP_LDA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_PC,
        SRC_RAM,
        SRC_IR,
        SRC_A,
        SRC_ALU
    } bus_src_e;

    // Winning bus driver: CO > RO > IO > AO > SO
    function automatic bus_src_e bus_sel(input logic [CTRL_W-1:0] cw);
        if (cw[CO_B])      return SRC_PC;
        else if (cw[RO_B]) return SRC_RAM;
        else if (cw[IO_B]) return SRC_IR;
        else if (cw[AO_B]) return SRC_A;
        else if (cw[SO_B]) return SRC_ALU;
        return SRC_NONE;
    endfunction

    // True when two or more bus drivers are asserted together
    function automatic logic bus_contention(input logic [CTRL_W-1:0] cw);
        logic [4:0] drv;
        drv = {cw[CO_B], cw[RO_B], cw[IO_B], cw[AO_B], cw[SO_B]};
        return (drv & (drv - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/sap_ram16x8.sv
// sap_ram16x8: 16x8 program/data RAM. Asynchronous read, synchronous
// write. While reset is held the program-load port owns the write side
// and the datapath write (RI) is ignored; contents survive reset.
module sap_ram16x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_prog_we,
    input  logic [ADDR_W-1:0] i_prog_addr,
    input  logic [DATA_W-1:0] i_prog_data,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Write port: program loader during reset, datapath RI otherwise
    always_ff @(posedge clk) begin
        if (i_reset) begin
            if (i_prog_we) r_mem[i_prog_addr] <= i_prog_data;
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: SAP-1 style single-bus datapath executing one 15-bit
// control word per rising edge. Optional carry/zero flags are built when
// the macro SAP_FLAGS_EN is defined.
module sap_datapath
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_wrd,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        Instruction,
    output logic              enable,
    output logic [DATA_W-1:0] out_val,
    output logic [DATA_W-1:0] bus_dbg,
    output logic              bus_err
`ifdef SAP_FLAGS_EN
    ,output logic [1:0]       flags
`endif
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_halted;
    logic              r_bus_err;
`ifdef SAP_FLAGS_EN
    logic [1:0]        r_flags;
    logic              w_carry;
`endif

    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_ram_rd;
    logic [DATA_W-1:0] w_b_opnd;

    // Subtract is A + ~B + 1; the +1 rides in as the SU bit itself
    assign w_b_opnd = ctrl_wrd[SU_B] ? ~r_b : r_b;
`ifdef SAP_FLAGS_EN
    assign {w_carry, w_alu} = {1'b0, r_a} + {1'b0, w_b_opnd}
                            + {{DATA_W{1'b0}}, ctrl_wrd[SU_B]};
`else
    assign w_alu = r_a + w_b_opnd + {{(DATA_W-1){1'b0}}, ctrl_wrd[SU_B]};
`endif

    sap_ram16x8 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk         (clk),
        .i_reset     (reset),
        .i_prog_we   (prog_we),
        .i_prog_addr (prog_addr),
        .i_prog_data (prog_data),
        .i_we        (ctrl_wrd[RI_B] & ~r_halted),
        .i_addr      (r_mar),
        .i_wdata     (w_bus),
        .o_rdata     (w_ram_rd)
    );

    // Shared bus: highest-priority driver wins, idle bus reads zero
    always_comb begin
        w_bus = '0;
        case (bus_sel(ctrl_wrd))
            SRC_PC:  w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
            SRC_RAM: w_bus = w_ram_rd;
            SRC_IR:  w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
            SRC_A:   w_bus = r_a;
            SRC_ALU: w_bus = w_alu;
            default: w_bus = '0;
        endcase
    end

    // Register loads; once halted nothing moves until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_mar     <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_out     <= '0;
            r_halted  <= 1'b0;
            r_bus_err <= 1'b0;
`ifdef SAP_FLAGS_EN
            r_flags   <= 2'b00;
`endif
        end else if (!r_halted) begin
            if (ctrl_wrd[MI_B]) r_mar <= w_bus[ADDR_W-1:0];
            if (ctrl_wrd[II_B]) r_ir  <= w_bus;
            if (ctrl_wrd[AI_B]) r_a   <= w_bus;
            if (ctrl_wrd[BI_B]) r_b   <= w_bus;
            if (ctrl_wrd[OI_B]) r_out <= w_bus;
            if (ctrl_wrd[J_B])       r_pc <= w_bus[ADDR_W-1:0];
            else if (ctrl_wrd[CE_B]) r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (ctrl_wrd[HLT_B])         r_halted  <= 1'b1;
            if (bus_contention(ctrl_wrd)) r_bus_err <= 1'b1;
`ifdef SAP_FLAGS_EN
            if (ctrl_wrd[SO_B]) r_flags <= {w_carry, (w_alu == '0)};
`endif
        end
    end

    assign Instruction = r_ir[DATA_W-1:DATA_W-4];
    assign enable      = ~r_halted;
    assign out_val     = r_out;
    assign bus_dbg     = w_bus;
    assign bus_err     = r_bus_err;
`ifdef SAP_FLAGS_EN
    assign flags       = r_flags;
`endif

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed bench for sap_datapath. Register state is
// observed through bus_dbg by briefly driving a read-only control word
// between edges. Flags are checked when SAP_FLAGS_EN is defined.
module tb_sap_datapath;

    localparam logic [14:0] J   = 15'h0001;
    localparam logic [14:0] CO  = 15'h0002;
    localparam logic [14:0] CE  = 15'h0004;
    localparam logic [14:0] OI  = 15'h0008;
    localparam logic [14:0] BI  = 15'h0010;
    localparam logic [14:0] SU  = 15'h0020;
    localparam logic [14:0] SO  = 15'h0040;
    localparam logic [14:0] AO  = 15'h0080;
    localparam logic [14:0] AI  = 15'h0100;
    localparam logic [14:0] II  = 15'h0200;
    localparam logic [14:0] IO  = 15'h0400;
    localparam logic [14:0] RO  = 15'h0800;
    localparam logic [14:0] RI  = 15'h1000;
    localparam logic [14:0] MI  = 15'h2000;
    localparam logic [14:0] HLT = 15'h4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] ctrl_wrd = '0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
    logic [3:0]  Instruction;
    logic        enable;
    logic [7:0]  out_val;
    logic [7:0]  bus_dbg;
    logic        bus_err;
`ifdef SAP_FLAGS_EN
    logic [1:0]  flags;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [14:0] cw;
        logic [14:0] pk;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [15];

    sap_datapath dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_wrd    (ctrl_wrd),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .Instruction (Instruction),
        .enable      (enable),
        .out_val     (out_val),
        .bus_dbg     (bus_dbg),
        .bus_err     (bus_err)
`ifdef SAP_FLAGS_EN
        ,.flags      (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Apply one control word across a rising edge
    task automatic step(input logic [14:0] cw);
        @(negedge clk);
        ctrl_wrd = cw;
        @(posedge clk);
        #1;
    endtask

    // Look at the bus under a read-only word, cleared before the next edge
    task automatic peek(input logic [14:0] cw, input string name, input logic [7:0] exp);
        @(negedge clk);
        ctrl_wrd = cw;
        #1;
        chk(name, bus_dbg, exp);
        ctrl_wrd = '0;
    endtask

    // One program-load write; reset must already be high
    task automatic load(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        reset    = 1'b1;
        ctrl_wrd = '0;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // LDA 14 / ADD 15 / OUT / HLT, as the controller would sequence it
        tbl[0]  = '{CO|MI,    CO, 8'h00};
        tbl[1]  = '{RO|II|CE, CO, 8'h01};
        tbl[2]  = '{IO|MI,    IO, 8'h0E};
        tbl[3]  = '{RO|AI,    AO, 8'h1C};
        tbl[4]  = '{CO|MI,    CO, 8'h01};
        tbl[5]  = '{RO|II|CE, IO, 8'h0F};
        tbl[6]  = '{IO|MI,    RO, 8'h0E};
        tbl[7]  = '{RO|BI,    SO, 8'h2A};
        tbl[8]  = '{AI|SO,    AO, 8'h2A};
        tbl[9]  = '{CO|MI,    CO, 8'h02};
        tbl[10] = '{RO|II|CE, CO, 8'h03};
        tbl[11] = '{AO|OI,    '0, 8'h00};
        tbl[12] = '{CO|MI,    CO, 8'h03};
        tbl[13] = '{RO|II|CE, CO, 8'h04};
        tbl[14] = '{HLT,      CO, 8'h04};

        // Program load under reset
        load(4'd0,  8'h1E);
        load(4'd1,  8'h2F);
        load(4'd2,  8'hE0);
        load(4'd3,  8'hF0);
        load(4'd14, 8'h1C);
        load(4'd15, 8'h0E);
        leave_reset();

        chk("rst_out",    out_val, 8'h00);
        chk("rst_enable", {7'd0, enable}, 8'h01);
        chk("rst_instr",  {4'd0, Instruction}, 8'h00);
        chk("rst_buserr", {7'd0, bus_err}, 8'h00);
        peek('0, "rst_idle_bus", 8'h00);
        peek(AO, "rst_a", 8'h00);
`ifdef SAP_FLAGS_EN
        chk("rst_flags", {6'd0, flags}, 8'h00);
`endif

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].cw);
            peek(tbl[i].pk, $sformatf("prog_step%0d", i), tbl[i].exp);
        end
        chk("prog_out",    out_val, 8'h2A);
        chk("prog_enable", {7'd0, enable}, 8'h00);
        chk("prog_instr",  {4'd0, Instruction}, 8'h0F);
`ifdef SAP_FLAGS_EN
        chk("add_flags", {6'd0, flags}, 8'h00);
`endif

        // Second program image for the corner-case sequences
        enter_reset();
        load(4'd0, 8'h39);
        load(4'd1, 8'h05);
        load(4'd3, 8'h49);
        load(4'd4, 8'h55);
        load(4'd9, 8'h07);
        leave_reset();
        chk("rst2_enable", {7'd0, enable}, 8'h01);

        // SUB wrap: 0x05 - 0x07 = 0xFE
        step(RO|II|CE);
        chk("sub_instr", {4'd0, Instruction}, 8'h03);
        step(IO|MI);
        step(RO|BI);
        step(CO|MI);
        step(RO|AI);
        peek(AO, "sub_a_before", 8'h05);
        peek(SU|SO, "sub_alu", 8'hFE);
        step(SU|SO|AI);
        peek(AO, "sub_a_after", 8'hFE);
`ifdef SAP_FLAGS_EN
        chk("sub_flags", {6'd0, flags}, 8'h00);
`endif

        // PC wraps 15 -> 0
        repeat (14) step(CE);
        peek(CO, "pc_15", 8'h0F);
        step(CE);
        peek(CO, "pc_wrap", 8'h00);

        // IR = 0x49, A = 0x55, then J beats CE
        repeat (3) step(CE);
        step(CO|MI);
        step(RO|II);
        chk("jmp_instr", {4'd0, Instruction}, 8'h04);
        step(CE);
        step(CO|MI);
        step(RO|AI);
        peek(AO, "a_55", 8'h55);
        step(CE|J|IO);
        peek(CO, "j_prio", 8'h09);

        // Contention: CO wins over AO and the error latches
        chk("buserr_pre", {7'd0, bus_err}, 8'h00);
        @(negedge clk);
        ctrl_wrd = CO|AO;
        #1;
        chk("contend_bus", bus_dbg, 8'h09);
        @(posedge clk);
        #1;
        chk("contend_err", {7'd0, bus_err}, 8'h01);
        peek(IO|AO|SO, "contend_io", 8'h09);
        step('0);
        step(AO|OI);
        chk("out_55", out_val, 8'h55);
        chk("buserr_sticky", {7'd0, bus_err}, 8'h01);

        // Halt: loads in the HLT word land, later words are ignored
        step(HLT|AI);
        chk("hlt_enable", {7'd0, enable}, 8'h00);
        peek(AO, "hlt_a_zero", 8'h00);
        step(AI|CO);
        peek(AO, "halted_a", 8'h00);
        peek(CO, "halted_pc", 8'h09);
        step(CO|OI);
        chk("halted_out", out_val, 8'h55);

        // Reset with a live control word: registers clear, RAM survives
        @(negedge clk);
        reset    = 1'b1;
        ctrl_wrd = AI|OI|CE|CO;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset    = 1'b0;
        ctrl_wrd = '0;
        chk("rst3_out",    out_val, 8'h00);
        chk("rst3_enable", {7'd0, enable}, 8'h01);
        chk("rst3_buserr", {7'd0, bus_err}, 8'h00);
        chk("rst3_instr",  {4'd0, Instruction}, 8'h00);
        peek(AO, "rst3_a",  8'h00);
        peek(CO, "rst3_pc", 8'h00);
        repeat (14) step(CE);
        step(CO|MI);
        peek(RO, "ram14_kept", 8'h1C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
